halve_tokens: RTL and testbench

Serial token compactor. It consumes a 1-bit token stream in which tokens arrive in pairs, emits one output token per completed pair over a valid/ready handshake, and buffers up to MAX_PENDING undelivered tokens. It is the receive-side counterpart of the token-doubling stage: it sits downstream of a doubled stream and recovers the original token count. It also flags sticky errors for buffer overflow and for dangling unpaired tokens.

---
 rtl/halve_tokens.sv | 112 +++++++++++
 tb/tb_halve_tokens.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/halve_tokens.sv
// Serial token compactor: pairs of input tokens become one buffered output token on a valid/ready port.
// Optional dangling-token check is enabled by defining HALVE_TOKENS_ODD_CHECK_EN.
module halve_tokens #(
    parameter int MAX_PENDING = 200,
    parameter int IDLE_GAP    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             a,
    output logic                             b_valid,
    input  logic                             b_ready,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             overflow,
    output logic                             odd_error
);

    localparam int              PW       = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0]   PEND_MAX = PW'(MAX_PENDING);

    generate
        if (MAX_PENDING < 1 || IDLE_GAP < 1) begin : g_param_check
            $error("halve_tokens: MAX_PENDING and IDLE_GAP must both be >= 1");
        end
    endgenerate

    logic          r_half;
    logic [PW-1:0] r_pending;
    logic          r_overflow;

    logic          w_inc;
    logic          w_dec;
    logic          w_drop_odd;
    logic          w_half_next;
    logic [PW-1:0] w_pending_next;
    logic          w_overflow_next;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_inc           = a && r_half;
        w_dec           = (r_pending != '0) && b_ready;
        w_pending_next  = r_pending;
        w_overflow_next = r_overflow;
        w_half_next     = r_half;

        if (w_inc && !w_dec) begin
            if (r_pending == PEND_MAX) begin
                w_overflow_next = 1'b1;
            end else begin
                w_pending_next = r_pending + PW'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_pending_next = r_pending - PW'(1);
        end

        if (a) begin
            w_half_next = ~r_half;
        end else if (w_drop_odd) begin
            w_half_next = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_half     <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_half     <= w_half_next;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
        end
    end

`ifdef HALVE_TOKENS_ODD_CHECK_EN
    localparam int            IW        = $clog2(IDLE_GAP + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_GAP);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_GAP - 1);

    logic [IW-1:0] r_idle;
    logic          r_odd_error;

    // The edge that would make the gap IDLE_GAP long is the one that abandons the half pair.
    assign w_drop_odd = !a && r_half && (r_idle == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle      <= '0;
            r_odd_error <= 1'b0;
        end else begin
            if (a) begin
                r_idle <= '0;
            end else if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + IW'(1);
            end
            if (w_drop_odd) begin
                r_odd_error <= 1'b1;
            end
        end
    end

    assign odd_error = r_odd_error;
`else
    assign w_drop_odd = 1'b0;
    assign odd_error  = 1'b0;
`endif

    assign b_valid  = (r_pending != '0);
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_halve_tokens.sv
// Scoreboard bench for halve_tokens: model tokens are queued on pair completion and popped on output beats.
// Odd-check expectations follow HALVE_TOKENS_ODD_CHECK_EN.
module tb_halve_tokens;

    localparam int MAX_PENDING = 200;
    localparam int IDLE_GAP    = 4;
    localparam int PW          = $clog2(MAX_PENDING + 1);
`ifdef HALVE_TOKENS_ODD_CHECK_EN
    localparam int ODD_EN = 1;
`else
    localparam int ODD_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a = 1'b0;
    logic          b_ready = 1'b0;
    logic          b_valid;
    logic [PW-1:0] pending;
    logic          overflow;
    logic          odd_error;

    halve_tokens #(.MAX_PENDING(MAX_PENDING), .IDLE_GAP(IDLE_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .pending   (pending),
        .overflow  (overflow),
        .odd_error (odd_error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_beats = 0;

    bit sb[$];
    bit m_half;
    bit m_ovf;
    bit m_odd;
    int m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_half = 0;
        m_ovf  = 0;
        m_odd  = 0;
        m_idle = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a = 1'b0;
        b_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check("rst_pending", pending, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_odd_error", odd_error, 0);
    endtask

    // One clock: drive inputs, compare the output beat, then advance the model past the edge.
    task automatic cycle(input bit ai, input bit ri);
        int sz;
        bit exp_xfer;
        bit inc;
        a = ai;
        b_ready = ri;
        sz = sb.size();
        exp_xfer = (sz != 0) && ri;
        check("b_valid", b_valid, (sz != 0));
        check("xfer", b_valid && ri, exp_xfer);
        if (b_valid && ri) n_beats++;
        @(posedge clk);
        #1;
        inc = ai && m_half;
        if (exp_xfer) void'(sb.pop_front());
        if (inc) begin
            if (!exp_xfer && sz == MAX_PENDING) m_ovf = 1;
            else sb.push_back(1'b1);
        end
        if (ODD_EN != 0) begin
            if (!ai && m_half && m_idle == IDLE_GAP - 1) begin
                m_odd  = 1;
                m_half = 0;
            end
            if (ai) m_idle = 0;
            else if (m_idle < IDLE_GAP) m_idle++;
        end
        if (ai) m_half = !m_half;
        check("pending", pending, sb.size());
        check("overflow", overflow, m_ovf);
        check("odd_error", odd_error, m_odd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats0;
        @(posedge clk);
        #1;
        do_reset();

        // Single pair with b_ready high: exactly one beat, the cycle after the second token.
        cycle(1, 1);
        check("t1_valid_early", b_valid, 0);
        cycle(1, 1);
        check("t1_valid_on", b_valid, 1);
        cycle(0, 1);
        check("t1_valid_off", b_valid, 0);
        check("t1_pending", pending, 0);
        cycle(0, 1);
        cycle(0, 1);
        check("t1_overflow", overflow, 0);
        check("t1_odd", odd_error, 0);

        // Ten tokens into a stalled port, then a back-to-back drain.
        for (int i = 0; i < 10; i++) cycle(1, 0);
        check("t2_pending5", pending, 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_beat", b_valid, 1);
            cycle(0, 1);
        end
        check("t2_drained", pending, 0);
        check("t2_valid_off", b_valid, 0);

        // Pair completion and output beat on the same edge.
        for (int i = 0; i < 7; i++) cycle(1, 0);
        check("t3_pending3", pending, 3);
        cycle(1, 1);
        check("t3_simul", pending, 3);
        for (int i = 0; i < 4; i++) cycle(0, 1);
        check("t3_drained", pending, 0);

        // Overflow: 201 pairs into a 200-deep buffer.
        do_reset();
        for (int i = 0; i < 400; i++) cycle(1, 0);
        check("t4_full", pending, MAX_PENDING);
        check("t4_no_ovf_yet", overflow, 0);
        cycle(1, 0);
        cycle(1, 0);
        check("t4_ovf", overflow, 1);
        check("t4_sat", pending, MAX_PENDING);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1);
            check("t4_ovf_sticky", overflow, 1);
        end
        check("t4_pending180", pending, 180);
        for (int i = 0; i < 180; i++) cycle(0, 1);
        check("t4_drained", pending, 0);
        check("t4_ovf_held", overflow, 1);

        // Dangling token across an idle gap.
        do_reset();
        beats0 = n_beats;
        cycle(1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1);
        check("t5_odd", odd_error, ODD_EN);
        check("t5_pending", pending, 0);
        cycle(1, 1);
        if (ODD_EN != 0) cycle(1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1);
        check("t5_tokens", n_beats - beats0, 1);
        check("t5_odd_held", odd_error, ODD_EN);

        // Reset in the middle of a burst with a half pair outstanding.
        do_reset();
        for (int i = 0; i < 15; i++) cycle(1, 0);
        check("t6_pending7", pending, 7);
        do_reset();
        cycle(0, 1);
        check("t6_no_beat", b_valid, 0);
        beats0 = n_beats;
        cycle(1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1);
        check("t6_no_pair", pending, 0);
        check("t6_no_tokens", n_beats - beats0, 0);

        // Random traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) cycle(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
